// File: rtl/rfile_writeback_if.sv
// rfile_writeback_if: retire handshake, RFile write port and decode bypass signals of the write-back stage.
interface rfile_writeback_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid, in_ready, reg_write, reg_dst, mem_to_reg, mem_rvalid;
   logic              WE, busy, fwd_a, fwd_b;
   logic [REG_AW-1:0] rt, rd, Rw, dec_rs, dec_rt;
   logic [DATA_W-1:0] alu_result, mem_rdata, Di, fwd_data;
   modport master (
      output in_valid, reg_write, reg_dst, mem_to_reg, rt, rd, alu_result, mem_rdata, mem_rvalid, dec_rs, dec_rt,
      input  in_ready, Rw, Di, WE, busy, fwd_a, fwd_b, fwd_data
   );
   modport slave (
      input  in_valid, reg_write, reg_dst, mem_to_reg, rt, rd, alu_result, mem_rdata, mem_rvalid, dec_rs, dec_rt,
      output in_ready, Rw, Di, WE, busy, fwd_a, fwd_b, fwd_data
   );
endinterface

// File: rtl/rfile_writeback.sv
// rfile_writeback: write-back stage driving the RFile write port; loads wait for mem_rvalid.
// Define WB_BYPASS_EN to drive fwd_a/fwd_b/fwd_data for same-cycle decode bypass.
module rfile_writeback #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic            clk,
   input logic            reset,
   rfile_writeback_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
   state_t            state_q, state_d;
   logic [REG_AW-1:0] rw_q, rw_d, dest_q, dest_d, dest;
   logic [DATA_W-1:0] di_q, di_d;
   logic              xfer, write_ok;
   assign dest         = bus.reg_dst ? bus.rd : bus.rt;
   assign write_ok     = bus.reg_write & (dest != '0);
   assign bus.in_ready = state_q != WAIT_MEM;
   assign xfer         = bus.in_valid & bus.in_ready;
   assign bus.WE       = state_q == COMMIT;
   assign bus.busy     = state_q != IDLE;
   assign bus.Rw       = rw_q;
   assign bus.Di       = di_q;
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      di_d    = di_q;
      dest_d  = dest_q;
      if (state_q == WAIT_MEM) begin
         if (bus.mem_rvalid) begin
            rw_d    = dest_q;
            di_d    = bus.mem_rdata;
            state_d = COMMIT;
         end
      end else if (xfer && write_ok && bus.mem_to_reg) begin
         dest_d  = dest;
         state_d = WAIT_MEM;
      end else if (xfer && write_ok) begin
         rw_d    = dest;
         di_d    = bus.alu_result;
         state_d = COMMIT;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rw_q    <= '0;
         di_q    <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         di_q    <= di_d;
         dest_q  <= dest_d;
      end
   end
`ifdef WB_BYPASS_EN
   assign bus.fwd_a    = bus.WE & (rw_q == bus.dec_rs) & (rw_q != '0);
   assign bus.fwd_b    = bus.WE & (rw_q == bus.dec_rt) & (rw_q != '0);
   assign bus.fwd_data = di_q;
`else
   assign bus.fwd_a    = 1'b0;
   assign bus.fwd_b    = 1'b0;
   assign bus.fwd_data = '0;
`endif
endmodule

// File: tb/tb_rfile_writeback.sv
// tb_rfile_writeback: random retire stream against a queue-based model of expected RFile writes.
module tb_rfile_writeback;
   typedef struct {
      logic [4:0]  rw;
      logic [31:0] di;
      int          cyc;
   } exp_t;
   logic clk = 0, reset = 0;
   int   total = 0, bad = 0, cyc = 0, rst_cnt = 0;
   exp_t q[$];
   rfile_writeback_if #(.DATA_W(32), .REG_AW(5)) bus ();
   rfile_writeback dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   task automatic rand_fields();
      bus.reg_write  = 1'($urandom_range(0, 1));
      bus.reg_dst    = 1'($urandom_range(0, 1));
      bus.mem_to_reg = 1'($urandom_range(0, 1));
      bus.rt         = 5'($urandom_range(0, 31));
      bus.rd         = 5'($urandom_range(0, 31));
      bus.alu_result = $urandom;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      bus.dec_rs     = 5'($urandom_range(0, 7));
      bus.dec_rt     = 5'($urandom_range(0, 7));
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
   endtask
   task automatic idle();
      step();
      rand_fields();
      bus.in_valid   = 1'b0;
      bus.mem_rvalid = 1'($urandom_range(0, 1));
   endtask
   task automatic issue(input logic wr, dst, m2r, input logic [4:0] t, d,
                        input logic [31:0] alu, md, input int gap);
      logic [4:0] dest;
      step();
      bus.in_valid   = 1'b1;
      bus.reg_write  = wr;
      bus.reg_dst    = dst;
      bus.mem_to_reg = m2r;
      bus.rt         = t;
      bus.rd         = d;
      bus.alu_result = alu;
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      chk("in_ready_issue", 32'(bus.in_ready), 32'd1);
      dest = dst ? d : t;
      if (wr && dest != 0) begin
         if (!m2r) q.push_back('{dest, alu, cyc + 1});
         else begin
            repeat (gap) begin
               step();
               rand_fields();
               bus.in_valid = 1'($urandom_range(0, 1));
               chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
               chk("busy_wait", 32'(bus.busy), 32'd1);
            end
            step();
            rand_fields();
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = md;
            chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
            q.push_back('{dest, md, cyc + 1});
         end
      end
   endtask
   initial begin : monitor
      logic [4:0]  last_rw = 0;
      logic [31:0] last_di = 0;
      int          seen = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst_cnt != seen) begin
            seen    = rst_cnt;
            last_rw = 0;
            last_di = 0;
         end
         if (bus.WE) begin
            if (q.size() == 0) chk("spurious_we", 32'(bus.WE), 32'd0);
            else begin
               e = q.pop_front();
               chk("Rw", 32'(bus.Rw), 32'(e.rw));
               chk("Di", bus.Di, e.di);
               chk("we_cycle", cyc, e.cyc);
               last_rw = e.rw;
               last_di = e.di;
`ifdef WB_BYPASS_EN
               chk("fwd_a", 32'(bus.fwd_a), 32'(e.rw == bus.dec_rs && e.rw != 0));
               chk("fwd_b", 32'(bus.fwd_b), 32'(e.rw == bus.dec_rt && e.rw != 0));
               chk("fwd_data", bus.fwd_data, e.di);
`else
               chk("fwd_a", 32'(bus.fwd_a), 32'd0);
               chk("fwd_b", 32'(bus.fwd_b), 32'd0);
               chk("fwd_data", bus.fwd_data, 32'd0);
`endif
            end
         end else begin
            if (q.size() != 0 && q[0].cyc <= cyc) begin
               chk("missing_we", 32'(bus.WE), 32'd1);
               void'(q.pop_front());
            end
            chk("Rw_hold", 32'(bus.Rw), 32'(last_rw));
            chk("Di_hold", bus.Di, last_di);
            chk("fwd_a_idle", 32'(bus.fwd_a), 32'd0);
            chk("fwd_b_idle", 32'(bus.fwd_b), 32'd0);
`ifdef WB_BYPASS_EN
            chk("fwd_data_idle", bus.fwd_data, last_di);
`else
            chk("fwd_data_idle", bus.fwd_data, 32'd0);
`endif
         end
      end
   end
   initial begin
      bus.in_valid = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.dec_rs = 0; bus.dec_rt = 0;
      rand_fields();
      #1 reset = 1;
      #1;
      chk("rst_WE", 32'(bus.WE), 32'd0);
      chk("rst_Rw", 32'(bus.Rw), 32'd0);
      chk("rst_Di", bus.Di, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      #1 reset = 0;
      rst_cnt++;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      issue(1, 1, 0, 5'd9, 5'd3, 32'd5, 32'd0, 0);
      issue(1, 0, 1, 5'd2, 5'd0, 32'd0, 32'hDEADBEEF, 3);
      idle();
      issue(1, 1, 0, 5'd6, 5'd0, 32'h1234, 32'd0, 0);
      issue(0, 1, 0, 5'd6, 5'd7, 32'h5678, 32'd0, 0);
      issue(1, 1, 0, 5'd0, 5'd1, 32'd7, 32'd0, 0);
      issue(1, 1, 0, 5'd0, 5'd4, 32'd9, 32'd0, 0);
      idle();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         issue($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
      end
      idle();
      idle();
      step();
      bus.in_valid = 1; bus.reg_write = 1; bus.reg_dst = 0; bus.mem_to_reg = 1; bus.rt = 5'd5;
      step();
      bus.in_valid = 0;
      chk("busy_pre_reset", 32'(bus.busy), 32'd1);
      #1 reset = 1;
      #1;
      chk("midrst_WE", 32'(bus.WE), 32'd0);
      chk("midrst_Rw", 32'(bus.Rw), 32'd0);
      chk("midrst_Di", bus.Di, 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      reset = 0;
      rst_cnt++;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.mem_rvalid = 1;
      idle();
      issue(1, 1, 0, 5'd0, 5'd1, 32'hCAFE, 32'd0, 0);
      repeat (4) idle();
      chk("drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
